match_logger: RTL
=================

# match_logger

Downstream stage of the Aho-Corasick matcher: consumes the per-byte state/match result that the matcher produces each time it advances (EN_MATCH, MATCH, the 8-bit state), tags every match with the byte position at which it occurred, and buffers the records in a FIFO for a host-side reader. It also keeps a saturating total-match counter and a sticky overflow flag.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256
- POS_W, 16, width of byte-position counter and of the position field

Ports:
- CLK  in  1  single clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- EN_MATCH  in  1  matcher advanced one byte this cycle; MATCH/STATE valid
- MATCH  in  1  match flag for that byte
- STATE  in  8  matcher state after that byte
- RD_EN  in  1  host read request
- RD_DATA  out  POS_W+8  {position, state} of popped record
- RD_VALID  out  1  RD_DATA valid this cycle
- EMPTY  out  1  FIFO holds 0 entries
- FULL  out  1  FIFO holds DEPTH entries
- LEVEL  out  $clog2(DEPTH)+1  current entry count
- MATCH_TOTAL  out  16  matches seen since reset, saturating at 16'hFFFF
- OVERFLOW  out  1  sticky: a match was lost because FIFO was full
- DROP_CNT  out  8  dropped-match counter (see Configuration)

## Operation
- Position counter POS (POS_W bits): reset 0; +1 on every cycle with EN_MATCH=1; wraps 2^POS_W-1 -> 0 silently.
- Record written on EN_MATCH=1 && MATCH=1: data {POS (pre-increment value), STATE}. MATCH ignored when EN_MATCH=0.
- Write accepted if !FULL, or if FULL and a read is accepted in the same cycle (simultaneous push/pop while full is legal; LEVEL unchanged).
- Write rejected when FULL with no same-cycle read: record discarded, OVERFLOW set to 1 (held until RST), DROP_CNT updated if compiled in.
- Read accepted on RD_EN=1 && !EMPTY; RD_EN while EMPTY ignored, RD_VALID stays 0, no pointer change.
- Simultaneous push and pop when EMPTY: only push occurs (pop sees empty); LEVEL 0 -> 1.
- Pointers: DEPTH-entry circular buffer, read/write pointers $clog2(DEPTH) bits, wrap naturally; LEVEL tracks occupancy; FULL = (LEVEL==DEPTH), EMPTY = (LEVEL==0).
- MATCH_TOTAL increments on every EN_MATCH&&MATCH, including dropped ones; saturates.
- Reset: POS=0, pointers=0, LEVEL=0, EMPTY=1, FULL=0, RD_VALID=0, RD_DATA=0, MATCH_TOTAL=0, OVERFLOW=0, DROP_CNT=0. Reset overrides any concurrent push/pop; in-flight read is cancelled (RD_VALID=0 next cycle).

## Timing
- Push: record written at edge where EN_MATCH&&MATCH sampled; EMPTY/FULL/LEVEL reflect it from the next cycle.
- Pop: registered read; RD_DATA/RD_VALID valid exactly 1 cycle after the accepting RD_EN edge; RD_VALID is a 1-cycle pulse per accepted read; RD_DATA holds last value otherwise.
- Back-to-back RD_EN every cycle yields one record per cycle.
- Write-to-read minimum latency: record pushed at edge N can be popped by RD_EN sampled at edge N+1, data out after edge N+2.
- OVERFLOW, DROP_CNT, MATCH_TOTAL update at the edge of the triggering event.

## Configuration
- Macro MATCH_LOGGER_DROP_COUNT_EN.
- Defined: DROP_CNT increments by 1 per rejected write, saturating at 8'hFF; reset 0.
- Undefined: no counter logic; DROP_CNT tied to 8'h00. OVERFLOW behaves identically in both builds.

## Test plan
- Reset then 5 EN_MATCH cycles with MATCH only on 3rd (STATE=8'h2A) -> LEVEL=1; RD_EN -> next cycle RD_VALID=1, RD_DATA={16'd2,8'h2A}, EMPTY=1.
- 17 consecutive matches (DEPTH=16, STATE=i) no reads -> FULL=1, LEVEL=16, OVERFLOW=1, MATCH_TOTAL=17, DROP_CNT=1 with macro / 0 without; 16 reads return positions 0..15 in order.
- FULL with EN_MATCH&&MATCH and RD_EN same cycle -> LEVEL stays 16, OVERFLOW stays 0, oldest record out, new record stored at tail.
- EMPTY with RD_EN and new match same cycle -> RD_VALID=0 next cycle, LEVEL=1; following RD_EN returns the record.
- Preset 2^16-1 EN_MATCH cycles then match on the next two -> recorded positions 16'hFFFF and 16'h0000.
- Assert RST while LEVEL=5 and RD_EN accepted -> next cycle LEVEL=0, EMPTY=1, RD_VALID=0, MATCH_TOTAL=0, OVERFLOW=0, position restarts at 0.

Source files
------------

// File: rtl/match_logger.sv
// Match logger: tags each matcher hit with its byte position and queues {position, state} records for a host reader.
// Optional build macro MATCH_LOGGER_DROP_COUNT_EN adds a saturating dropped-match counter on DROP_CNT.
module match_logger #(
  parameter int DEPTH = 16,
  parameter int POS_W = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EN_MATCH,
  input  logic                     MATCH,
  input  logic [7:0]               STATE,
  input  logic                     RD_EN,
  output logic [POS_W+7:0]         RD_DATA,
  output logic                     RD_VALID,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic [15:0]              MATCH_TOTAL,
  output logic                     OVERFLOW,
  output logic [7:0]               DROP_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [POS_W+7:0] mem [DEPTH];
  logic [POS_W-1:0] pos;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_req;
  logic             pop;
  logic             push;
  logic             drop;

  assign EMPTY    = (LEVEL == '0);
  assign FULL     = (LEVEL == LVL_FULL);
  assign push_req = EN_MATCH & MATCH;
  assign pop      = RD_EN & ~EMPTY;
  // A full FIFO still accepts a record when the same cycle frees a slot.
  assign push     = push_req & (~FULL | pop);
  assign drop     = push_req & FULL & ~pop;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pos         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      LEVEL       <= '0;
      RD_VALID    <= 1'b0;
      RD_DATA     <= '0;
      MATCH_TOTAL <= '0;
      OVERFLOW    <= 1'b0;
    end else begin
      RD_VALID <= pop;
      if (pop) begin
        RD_DATA <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (push && !pop) begin
        LEVEL <= LEVEL + LW'(1);
      end else if (!push && pop) begin
        LEVEL <= LEVEL - LW'(1);
      end
      if (EN_MATCH) begin
        pos <= pos + POS_W'(1);
      end
      if (push_req && MATCH_TOTAL != 16'hFFFF) begin
        MATCH_TOTAL <= MATCH_TOTAL + 16'd1;
      end
      if (drop) begin
        OVERFLOW <= 1'b1;
      end
    end
  end

  // Storage is not reset; only entries between the pointers are ever read.
  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      mem[wr_ptr] <= {pos, STATE};
    end
  end

`ifdef MATCH_LOGGER_DROP_COUNT_EN
  logic [7:0] drop_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      drop_cnt <= 8'h00;
    end else if (drop && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign DROP_CNT = drop_cnt;
`else
  assign DROP_CNT = 8'h00;
`endif

endmodule
